// File: rtl/bus_arbit_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encoding,
// default sizing and a width helper.
package bus_arbit_pkg;

    localparam logic IDLE_STATE  = 1'b0;
    localparam logic GRANT_STATE = 1'b1;

    typedef enum logic {
        IDLE  = IDLE_STATE,
        GRANT = GRANT_STATE
    } state_e;

    localparam int DEFAULT_N_MASTER   = 2;
    localparam int DEFAULT_MAX_TENURE = 16;

    // Bits needed to index 'value' items, never less than one.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit at or
// after 'ptr', wrapping from N-1 back to 0. Shared with other schedulers.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IDX_W:0] idx_sum;

    // Rotate so the pointer position lands on bit 0.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[N-1:0];

    // Lowest set bit of the rotated vector, mapped back to a master index.
    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves
        // it unassigned; a missing default here would infer a latch.
        winner  = '0;
        valid   = 1'b0;
        idx_sum = '0;
        // Scan downward so the lowest matching offset is the last one written.
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                idx_sum = {1'b0, ptr} + (IDX_W + 1)'(j);
                if (idx_sum >= (IDX_W + 1)'(N)) begin
                    idx_sum = idx_sum - (IDX_W + 1)'(N);
                end
                winner = idx_sum[IDX_W-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbit_rr.sv
// Round-robin bus arbiter with bounded tenure. Owners are preempted after
// MAX_TENURE cycles only while another master waits; every handover passes
// through one idle cycle so grants never overlap.
module bus_arbit_rr
    import bus_arbit_pkg::*;
#(
    parameter int N_MASTER   = DEFAULT_N_MASTER,
    parameter int IDX_W      = clog2_min1(DEFAULT_N_MASTER),
    parameter int MAX_TENURE = DEFAULT_MAX_TENURE
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_MASTER-1:0] m_req,
    output logic [N_MASTER-1:0] m_grant,
    output logic [IDX_W-1:0]    m_sel,
    output logic                bus_busy
);

    localparam int              TEN_W      = clog2_min1((MAX_TENURE > 1) ? MAX_TENURE : 2);
    localparam logic [TEN_W-1:0] TEN_LAST  = (MAX_TENURE > 0) ? TEN_W'(MAX_TENURE - 1) : '0;
    localparam logic            PREEMPT_EN = (MAX_TENURE != 0);
    localparam logic [IDX_W:0]  N_EXT      = (IDX_W + 1)'(N_MASTER);

    state_e           state;
    logic [TEN_W-1:0] tenure;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [IDX_W:0]   ptr_sum;
    logic [IDX_W-1:0] next_ptr;
    logic             owner_req;
    logic             other_req;

    rr_pick #(
        .N     (N_MASTER),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (m_req),
        .ptr    (ptr),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // Pointer moves one past the winner, wrapping at N_MASTER.
    assign ptr_sum  = {1'b0, pick_idx} + (IDX_W + 1)'(1);
    assign next_ptr = (ptr_sum == N_EXT) ? '0 : ptr_sum[IDX_W-1:0];

    // m_grant is one-hot while granted, so masking picks out the owner.
    assign owner_req = |(m_req & m_grant);
    assign other_req = |(m_req & ~m_grant);
    assign bus_busy  = |m_grant;

    // Arbitration FSM with registered grant, select, pointer and tenure.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values and the update order is irrelevant.
        if (!reset_n) begin
            state   <= IDLE;
            m_grant <= '0;
            m_sel   <= '0;
            ptr     <= '0;
            tenure  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= GRANT;
                        m_grant <= N_MASTER'(1) << pick_idx;
                        m_sel   <= pick_idx;
                        tenure  <= '0;
                        ptr     <= next_ptr;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        // Release; m_sel keeps the last owner for the bus mux.
                        state   <= IDLE;
                        m_grant <= '0;
                    end else if (PREEMPT_EN && (tenure == TEN_LAST) && other_req) begin
                        state   <= IDLE;
                        m_grant <= '0;
                    end else if (tenure != TEN_LAST) begin
                        tenure <= tenure + TEN_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    m_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbit_rr.sv
// Self-checking bench for bus_arbit_rr: a 2-master instance with tenure 4
// and a 4-master instance with preemption disabled, both compared every
// cycle against a behavioural ownership model.
module tb_bus_arbit_rr;

    logic       clk;
    logic       reset_n;
    logic [1:0] req2;
    logic [1:0] grant2;
    logic       sel2;
    logic       busy2;
    logic [3:0] req4;
    logic [3:0] grant4;
    logic [1:0] sel4;
    logic       busy4;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // Model state per instance: 0 = two masters, 1 = four masters.
    int n_of  [2] = '{2, 4};
    int mt_of [2] = '{4, 0};
    int own   [2];   // current owner, -1 when the bus is idle
    int sel   [2];   // last owner
    int ptr   [2];   // first master to consider at the next arbitration
    int served[2];   // grant cycles the current owner has been visible

    bus_arbit_rr #(.N_MASTER(2), .IDX_W(1), .MAX_TENURE(4)) dut2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .m_req    (req2),
        .m_grant  (grant2),
        .m_sel    (sel2),
        .bus_busy (busy2)
    );

    bus_arbit_rr #(.N_MASTER(4), .IDX_W(2), .MAX_TENURE(0)) dut4 (
        .clk      (clk),
        .reset_n  (reset_n),
        .m_req    (req4),
        .m_grant  (grant4),
        .m_sel    (sel4),
        .bus_busy (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            own[d]    = -1;
            sel[d]    = 0;
            ptr[d]    = 0;
            served[d] = 0;
        end
    endtask

    // One clock edge of the arbitration rules, given the sampled request word.
    task automatic model_step(input int d, input logic [7:0] req);
        int n;
        logic [7:0] others;
        n = n_of[d];
        if (own[d] < 0) begin
            for (int k = 0; k < n; k++) begin
                int m;
                m = (ptr[d] + k) % n;
                if (own[d] < 0 && req[m]) begin
                    own[d]    = m;
                    sel[d]    = m;
                    served[d] = 1;
                end
            end
            if (own[d] >= 0) ptr[d] = (own[d] + 1) % n;
        end else begin
            others = req & ~(8'd1 << own[d]);
            if (!req[own[d]]) own[d] = -1;
            else if (mt_of[d] != 0 && served[d] >= mt_of[d] && others != 8'd0) own[d] = -1;
            else served[d]++;
        end
    endtask

    task automatic check_all();
        check("d2_grant",  32'(grant2), (own[0] < 0) ? 32'd0 : (32'd1 << own[0]));
        check("d2_sel",    32'(sel2), 32'(sel[0]));
        check("d2_busy",   32'(busy2), 32'(own[0] >= 0));
        check("d2_onehot", 32'($onehot0(grant2)), 32'd1);
        check("d4_grant",  32'(grant4), (own[1] < 0) ? 32'd0 : (32'd1 << own[1]));
        check("d4_sel",    32'(sel4), 32'(sel[1]));
        check("d4_busy",   32'(busy4), 32'(own[1] >= 0));
        check("d4_onehot", 32'($onehot0(grant4)), 32'd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, {6'd0, req2});
        model_step(1, {4'd0, req4});
        #1;
        check_all();
    endtask

    initial begin
        int cnt4[4];
        int order_idx;
        int prev_own;

        req2    = '0;
        req4    = '0;
        reset_n = 1'b1;
        model_reset();
        #1 reset_n = 1'b0;
        #2 check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Four masters, no preemption, each releasing after two grant cycles.
        req4      = 4'hF;
        order_idx = 0;
        for (int i = 0; i < 4; i++) cnt4[i] = 0;
        repeat (20) begin
            prev_own = own[1];
            cycle();
            if (prev_own < 0 && own[1] >= 0) begin
                check("d4_order", 32'(sel4), 32'(order_idx % 4));
                order_idx++;
            end
            for (int i = 0; i < 4; i++) begin
                if (own[1] == i) begin
                    cnt4[i]++;
                    if (cnt4[i] == 2) begin
                        req4[i] = 1'b0;
                        cnt4[i] = 0;
                    end else begin
                        req4[i] = 1'b1;
                    end
                end else begin
                    req4[i] = 1'b1;
                end
            end
        end
        req4 = '0;
        repeat (2) cycle();

        // Single master request for three cycles.
        cycle();
        req2 = 2'b01;
        repeat (3) cycle();
        req2 = 2'b00;
        repeat (3) cycle();

        // Both masters held: tenure-limited alternation with dead slots.
        req2 = 2'b11;
        repeat (24) cycle();
        req2 = 2'b00;
        repeat (2) cycle();

        // Uncontested owner keeps the bus.
        req2 = 2'b10;
        repeat (22) cycle();
        req2 = 2'b00;
        repeat (2) cycle();

        // Early release handover.
        req2 = 2'b01;
        cycle();
        check("er_grant0", 32'(grant2), 32'd1);
        req2 = 2'b11;
        cycle();
        req2 = 2'b10;
        cycle();
        check("er_dead", 32'(grant2), 32'd0);
        cycle();
        check("er_grant1", 32'(grant2), 32'd2);
        req2 = 2'b00;
        repeat (2) cycle();
        req2 = 2'b11;
        cycle();
        check("er_ptr", 32'(grant2), 32'd1);
        req2 = 2'b00;
        repeat (2) cycle();

        // Asynchronous reset while master 1 owns the bus.
        req2 = 2'b10;
        repeat (3) cycle();
        check("rst_pre", 32'(grant2), 32'd2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_grant", 32'(grant2), 32'd0);
        check("rst_sel",   32'(sel2), 32'd0);
        check("rst_busy",  32'(busy2), 32'd0);
        model_reset();
        req2 = 2'b11;
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        check("rst_first", 32'(grant2), 32'd1);
        req2 = 2'b00;
        repeat (2) cycle();

        // Randomised request levels on both instances.
        repeat (400) begin
            for (int i = 0; i < 2; i++) if ($urandom_range(4) == 0) req2[i] = ~req2[i];
            for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) req4[i] = ~req4[i];
            cycle();
        end
        req2 = '0;
        req4 = '0;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bus_arbit_rr.md
Name: bus_arbit_rr

Overview:
- Multi-master bus arbiter that shares one bus among N_MASTER requesters.
- Round-robin fairness with a bounded tenure: an owner that exceeds MAX_TENURE cycles is preempted only while another master is waiting.
- Sits between the master request lines and the bus mux select.
- A one-cycle dead slot separates consecutive owners, so grants never overlap.

Parameters:
- N_MASTER, 2, number of requesting masters (2..8).
- IDX_W, 1, width of master index; must equal clog2(N_MASTER) (min 1).
- MAX_TENURE, 16, maximum grant cycles before preemption if contended; 0 disables preemption.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- m_req  input  N_MASTER  per-master bus request, level; held high for the whole transfer.
- m_grant  output  N_MASTER  one-hot grant, registered; all-zero when bus idle.
- m_sel  output  IDX_W  index of current/last owner, drives bus mux.
- bus_busy  output  1  high when any grant bit is high (OR of m_grant).

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Reset values: state=IDLE, m_grant=0, m_sel=0, bus_busy=0, rr pointer=0, tenure counter=0. Reset asserted mid-grant drops the grant immediately (async).
- States: IDLE, GRANT. All outputs are registered (Moore); no combinational path from m_req to m_grant.
- IDLE:
  - If m_req==0, stay in IDLE.
  - Otherwise the winner is the first set bit of m_req scanning upward from the rr pointer, wrapping N_MASTER-1 to 0.
  - On the next edge: state=GRANT, m_grant=onehot(winner), m_sel=winner, tenure=0, pointer=(winner+1) mod N_MASTER.
  - Latency: request sampled at edge k produces grant after edge k (visible cycle k+1).
- GRANT, evaluated each edge with owner o:
  - If m_req[o]==0 (release): go to IDLE, m_grant=0. m_sel keeps o.
  - Else if MAX_TENURE!=0, tenure==MAX_TENURE-1, and any other m_req bit is set (preempt): go to IDLE, m_grant=0.
  - Else stay in GRANT; tenure increments and saturates at MAX_TENURE-1.
  - An uncontested owner keeps the bus indefinitely.
- Dead slot: every ownership change passes through exactly one IDLE cycle with m_grant=0, so back-to-back grants to different masters are never adjacent. The same master re-requesting after release also sees one IDLE cycle.
- Simultaneous release and preempt condition: treated as release; the outcome is identical.
- Fairness: because the pointer moves past each winner, a continuously requesting master waits at most (N_MASTER-1) tenures plus one dead cycle per handover.
- Requests arriving during GRANT are not latched; only the m_req level in IDLE is arbitrated.
- m_grant is always one-hot or zero (invariant for assertions). bus_busy == |m_grant.

Decomposition:
- Shared package bus_arbit_pkg holds:
  - state encoding constants IDLE_STATE=1'b0, GRANT_STATE=1'b1;
  - default N_MASTER and MAX_TENURE;
  - a clog2 helper function.
- One natural sub-module: rr_pick.
  - Purely combinational rotate / priority-find / unrotate.
  - Inputs: req vector, pointer. Outputs: winner index, valid.
  - Reused by future DMA/port schedulers.
- The FSM, pointer and tenure counter stay in bus_arbit_rr.

Test Plan:
(N_MASTER=2, MAX_TENURE=4 unless noted)
- Single master: reset, raise m_req=01 at cycle 2 for 3 cycles -> m_grant=01 in cycles 3-5, 00 at cycle 6, m_sel=0, bus_busy matches.
- Simultaneous: m_req=11 from reset, both held long -> grants 01 (4 cycles), 00 (1), 10 (4), 00 (1), 01 ...; never 11.
- Uncontested hold: m_req=10 held 20 cycles -> m_grant=10 continuously for 20 cycles after the 1-cycle latency; no preemption.
- Early release handover: m_req=01 granted, m_req[1] rises at grant cycle 1, m_req[0] falls at grant cycle 2 -> 00 for one cycle, then 10; pointer now favours master 0.
- Reset mid-grant: assert reset_n=0 asynchronously while m_grant=10 -> m_grant=00 and m_sel=0 before the next clk edge. After release with m_req=11, master 0 wins first.
- N_MASTER=4, MAX_TENURE=0, m_req=1111 with each master releasing after 2 cycles -> grant order 0,1,2,3,0 with one idle cycle between each.
